// File: rtl/cache_pkg.sv
// cache_pkg: line geometry and adapter FSM states shared across the cache slice
package cache_pkg;
  localparam int s_offset = 5;
  localparam int WORDS = 2**(s_offset-2);
  localparam int LINE_W = 32*WORDS;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
endpackage

// File: rtl/mem_line_adapter_if.sv
// mem_line_adapter_if: cache-side line port plus memory-side word port
interface mem_line_adapter_if #(parameter int WORDS = cache_pkg::WORDS);
  logic line_read;
  logic line_write;
  logic [31:0] line_addr;
  logic [32*WORDS-1:0] line_wdata;
  logic [32*WORDS-1:0] line_rdata;
  logic line_resp;
  logic [31:0] mem_addr;
  logic mem_rd;
  logic mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_ready;
  modport slave(
    input line_read, line_write, line_addr, line_wdata, mem_rdata, mem_ready,
    output line_rdata, line_resp, mem_addr, mem_rd, mem_wr, mem_wdata
  );
  modport master(
    output line_read, line_write, line_addr, line_wdata, mem_rdata, mem_ready,
    input line_rdata, line_resp, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_line_adapter.sv
// mem_line_adapter: serialises line fills/writebacks into 32-bit word memory beats
module mem_line_adapter #(
  parameter int s_offset = cache_pkg::s_offset,
  parameter int WORDS = 2**(s_offset-2)
) (
  input logic clk,
  input logic rst,
  mem_line_adapter_if.slave b
);
  import cache_pkg::*;
  localparam int CW = $clog2(WORDS);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] base;
  logic [32*WORDS-1:0] wbuf, rbuf;
  logic busy, last, beat, unused_addr;
  assign unused_addr = ^b.line_addr[s_offset-1:0];
  assign busy = state == WRITE || state == READ;
  assign last = cnt == CW'(WORDS-1);
  assign beat = busy && b.mem_ready;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (b.line_write ? WRITE : b.line_read ? READ : IDLE)
            : state == DONE ? IDLE
            : (beat && last) ? DONE : state;
  end
  // memory-side outputs are decoded from state so reset clears them on the same edge
  always_comb begin
    b.mem_wr = state == WRITE;
    b.mem_rd = state == READ;
    b.mem_addr = busy ? base + 32'({cnt, 2'b00}) : '0;
    b.mem_wdata = state == WRITE ? wbuf[32*cnt +: 32] : '0;
    b.line_resp = state == DONE;
    b.line_rdata = rbuf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      wbuf <= '0;
      rbuf <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        base <= {b.line_addr[31:s_offset], {s_offset{1'b0}}};
        wbuf <= b.line_wdata;
        cnt <= '0;
      end
      if (beat) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == READ) rbuf[32*cnt +: 32] <= b.mem_rdata;
      end
    end
  end
endmodule
